// File: rtl/vram_arb_pkg.sv
// vram_arbiter shared types: slot owner tag and RAM bus widths.
// Optional blank-interval DMA slots: VRAM_ARB_BLANK_DMA_EN.
package vram_arb_pkg;

  localparam int AW = 16;
  localparam int DW = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VGA  = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_DMA  = 2'd3
  } owner_e;

endpackage

// File: rtl/vram_starve_mon.sv
// DMA wait counter (saturating) and sticky starvation flag.
// Counter clears on grant or when the request drops.
module vram_starve_mon
  import vram_arb_pkg::*;
#(
  parameter int MAX_WAIT = 64
) (
  input  logic clk25,
  input  logic rst,
  input  logic dma_req_i,
  input  logic dma_gnt_i,
  input  logic starve_clr_i,
  output logic dma_starve_o
);

  localparam logic [7:0] MAXW = 8'(MAX_WAIT);

  logic [7:0] cnt_q, cnt_d;
  logic       starve_q, starve_d;
  logic       set;

  always_comb begin
    cnt_d = cnt_q;
    if (!dma_req_i || dma_gnt_i) begin
      cnt_d = '0;
    end else if (cnt_q != MAXW) begin
      cnt_d = cnt_q + 8'd1;
    end
    // a coinciding clear loses against a fresh set
    set      = dma_req_i && !dma_gnt_i && (cnt_d == MAXW);
    starve_d = set | (starve_q & ~starve_clr_i);
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      starve_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
    end
  end

  assign dma_starve_o = starve_q;

endmodule

// File: rtl/vram_arbiter.sv
// Time-slotted VRAM arbiter: CPU odd slots, VGA even slots, DMA fills gaps.
// Define VRAM_ARB_BLANK_DMA_EN to hand even slots to DMA during blanking.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int DMA_MAX_WAIT = 64
) (
  input  logic          clk25,
  input  logic          rst,
  input  logic          cpu_phase_i,
  input  logic          cpu_sel_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_dbw_i,
  output logic [DW-1:0] cpu_dbr_o,
  input  logic [AW-1:0] vga_addr_i,
  input  logic          vga_blank_i,
  output logic [DW-1:0] vga_data_o,
  input  logic          dma_req_i,
  input  logic          dma_we_i,
  input  logic [AW-1:0] dma_addr_i,
  input  logic [DW-1:0] dma_dbw_i,
  output logic          dma_gnt_o,
  output logic          dma_rvalid_o,
  output logic [DW-1:0] dma_dbr_o,
  input  logic          starve_clr_i,
  output logic          dma_starve_o,
  output logic          phase_err_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_dbw_o,
  output logic          ram_we_o,
  input  logic [DW-1:0] ram_dbr_i
);

  owner_e        own;
  owner_e        tag_q;
  logic          rd_q;
  logic [DW-1:0] cpu_dbr_q;
  logic [DW-1:0] dma_dbr_q;
  logic          prev_q;
  logic          prev_vld_q;
  logic          phase_err_q;

  always_comb begin
    own = OWN_VGA;
    if (cpu_phase_i) begin
      if (cpu_sel_i) begin
        own = OWN_CPU;
      end else if (dma_req_i) begin
        own = OWN_DMA;
      end else begin
        own = OWN_NONE;
      end
    end
`ifdef VRAM_ARB_BLANK_DMA_EN
    else if (vga_blank_i && dma_req_i) begin
      own = OWN_DMA;
    end
`endif
  end

`ifndef VRAM_ARB_BLANK_DMA_EN
  logic unused_blank;
  assign unused_blank = vga_blank_i;
`endif

  always_comb begin
    ram_addr_o = '0;
    ram_dbw_o  = '0;
    ram_we_o   = 1'b0;
    unique case (own)
      OWN_CPU: begin
        ram_addr_o = cpu_addr_i;
        ram_dbw_o  = cpu_dbw_i;
        ram_we_o   = cpu_we_i & ~rst;
      end
      OWN_DMA: begin
        ram_addr_o = dma_addr_i;
        ram_dbw_o  = dma_dbw_i;
        ram_we_o   = dma_we_i & ~rst;
      end
      OWN_VGA: begin
        ram_addr_o = vga_addr_i;
      end
      default: begin
      end
    endcase
  end

  assign dma_gnt_o = (own == OWN_DMA) && !rst;

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      tag_q       <= OWN_NONE;
      rd_q        <= 1'b0;
      cpu_dbr_q   <= '0;
      dma_dbr_q   <= '0;
      prev_q      <= 1'b0;
      prev_vld_q  <= 1'b0;
      phase_err_q <= 1'b0;
    end else begin
      tag_q      <= own;
      rd_q       <= (own == OWN_DMA) && !dma_we_i;
      prev_q     <= cpu_phase_i;
      prev_vld_q <= 1'b1;
      if (tag_q == OWN_CPU) begin
        cpu_dbr_q <= ram_dbr_i;
      end
      if (dma_rvalid_o) begin
        dma_dbr_q <= ram_dbr_i;
      end
      if (prev_vld_q && (cpu_phase_i == prev_q)) begin
        phase_err_q <= 1'b1;
      end
    end
  end

  // RAM data arrives the cycle after the grant; forward it with rvalid
  assign dma_rvalid_o = (tag_q == OWN_DMA) && rd_q;
  assign dma_dbr_o    = dma_rvalid_o ? ram_dbr_i : dma_dbr_q;
  assign cpu_dbr_o    = cpu_dbr_q;
  assign vga_data_o   = ram_dbr_i;
  assign phase_err_o  = phase_err_q;

  vram_starve_mon #(
    .MAX_WAIT(DMA_MAX_WAIT)
  ) u_starve (
    .clk25       (clk25),
    .rst         (rst),
    .dma_req_i   (dma_req_i),
    .dma_gnt_i   (dma_gnt_o),
    .starve_clr_i(starve_clr_i),
    .dma_starve_o(dma_starve_o)
  );

endmodule
